// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// default load address and word geometry.
package imem_loader_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h0100_0000;
    localparam int          BYTES_PER_WORD  = 4;
    localparam int          LANE_W          = $clog2(BYTES_PER_WORD);

    // ST_VERIFY is only reachable when IMEM_LOADER_VERIFY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Lane counter plus little-endian byte-to-word assembler. The first byte
// pushed after a clear lands in [7:0], the fourth in [31:24]. Lanes that
// are never filled keep the zero left by the clear.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,      // restart at lane 0 with an all-zero word
    input  logic        push,       // a byte is accepted this cycle
    input  logic        push_last,  // the byte being pushed is the last of the load
    input  logic [7:0]  push_data,
    output logic [31:0] word,
    output logic        full,       // this push fills the top lane
    output logic        last        // this push is the final byte of the load
);

    logic [LANE_W-1:0] lane;

    assign full = push & (lane == LANE_W'(BYTES_PER_WORD - 1));
    assign last = push & push_last;

    // Lane pointer and word buffer; clear has priority over push.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lane <= '0;
            word <= '0;
        end else if (push) begin
            word[{lane, 3'b000} +: 8] <= push_data;
            lane                      <= lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs an 8-bit valid/ready byte stream into
// 32-bit little-endian words and writes them to the instruction memory
// starting at PC_INIT. Owns the memory write port only while busy is high.
//
// Build option: IMEM_LOADER_VERIFY_EN adds a VERIFY state after each write
// that reads the word back through mem_data_out and aborts the load with
// error set on a mismatch.
//
// Byte handshake: a byte transfers on a rising clock edge where in_valid and
// in_ready are both high. in_ready depends only on registered state, never on
// in_valid. The source must hold in_data stable while in_valid is high and the
// byte has not yet been accepted.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] PC_INIT   = PC_INIT_DEFAULT,
    parameter int          MEM_DEPTH = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] byte_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_read_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] words_written,
    output state_t      state_dbg
);

    state_t      state;
    logic [31:0] addr;
    logic [31:0] remaining;
    logic        wr_q;

    logic        push;
    logic        push_last;
    logic        packer_clear;
    logic        word_full;
    logic        word_last;
    logic        word_done;
    logic [31:0] word;
    logic        oversize;
    logic        start_load;
    logic        advance;

    assign push       = in_ready & in_valid;
    assign push_last  = (remaining == 32'd1);
    assign word_done  = word_full | word_last;
    assign oversize   = (byte_count > 32'(MEM_DEPTH));
    assign start_load = (state == ST_IDLE) & start & (byte_count != 32'd0) & ~oversize;

`ifdef IMEM_LOADER_VERIFY_EN
    logic verify_ok;
    assign verify_ok = (mem_data_out == word);
    assign advance   = (state == ST_VERIFY) & verify_ok;
`else
    logic unused_mem_data_out;
    assign unused_mem_data_out = ^mem_data_out;
    assign advance             = (state == ST_WRITE);
`endif

    assign packer_clear = start_load | advance;

    // A reset landing in the WRITE cycle must not commit the write.
    assign mem_read_write = wr_q & ~reset;
    assign mem_address    = addr;
    assign mem_data_in    = word;
    assign state_dbg      = state;

    imem_loader_word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (packer_clear),
        .push      (push),
        .push_last (push_last),
        .push_data (in_data),
        .word      (word),
        .full      (word_full),
        .last      (word_last)
    );

    // Load FSM with registered handshake/strobe outputs set on each transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr          <= PC_INIT;
            remaining     <= '0;
            error         <= 1'b0;
            words_written <= '0;
            in_ready      <= 1'b0;
            wr_q          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            wr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (byte_count == 32'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (oversize) begin
                            error <= 1'b1;
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            error         <= 1'b0;
                            words_written <= '0;
                            addr          <= PC_INIT;
                            remaining     <= byte_count;
                            state         <= ST_COLLECT;
                            in_ready      <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (push) begin
                        remaining <= remaining - 32'd1;
                        if (word_done) begin
                            state    <= ST_WRITE;
                            in_ready <= 1'b0;
                            wr_q     <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    words_written <= words_written + 32'd1;
`ifdef IMEM_LOADER_VERIFY_EN
                    state <= ST_VERIFY;
`else
                    addr <= addr + 32'(BYTES_PER_WORD);
                    if (remaining == 32'd0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= ST_COLLECT;
                        in_ready <= 1'b1;
                    end
`endif
                end
`ifdef IMEM_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    if (verify_ok) begin
                        addr <= addr + 32'(BYTES_PER_WORD);
                        if (remaining == 32'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_COLLECT;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        error <= 1'b1;
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: expected memory writes are queued as
// {address, data} and checked as the DUT issues them; status outputs are
// checked at fixed points of each load.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam logic [31:0] PC     = 32'h0100_0000;
    localparam int          DEPTH  = 4096;

    // Clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // DUT connections
    logic        start = 1'b0;
    logic [31:0] byte_count = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        mem_read_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] words_written;
    state_t      state_dbg;

    imem_loader #(.PC_INIT(PC), .MEM_DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .byte_count    (byte_count),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_read_write(mem_read_write),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written),
        .state_dbg     (state_dbg)
    );

    // Memory model: 16 words, synchronous write, asynchronous read.
    logic [31:0] mem_arr [0:15];
    logic        mem_clear = 1'b0;
    logic        corrupt   = 1'b0;

    assign mem_data_out = mem_arr[mem_address[5:2]];

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
        end else if (mem_read_write) begin
            if (corrupt && mem_address[5:2] == 4'd0)
                mem_arr[mem_address[5:2]] <= mem_data_in ^ 32'h0000_0001;
            else
                mem_arr[mem_address[5:2]] <= mem_data_in;
        end
    end

    // Scoreboard
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (mem_read_write === 1'b1) begin
            check("in_ready_during_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_read_write), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("write_addr", mem_address, exp_e[63:32]);
                check("write_data", mem_data_in, exp_e[31:0]);
            end
        end
    end

    // Driver tasks (all run just after the falling edge)
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic start_load(input logic [31:0] cnt);
        start      = 1'b1;
        byte_count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 40; t++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("byte_accept_timeout", 32'(ok), 32'd1);
        tick();
    endtask

    task automatic send_seq(input logic [7:0] first, input int n, input bit gap);
        for (int i = 0; i < n; i++) send_byte(first + 8'(i), gap);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic clear_mem();
        mem_clear = 1'b1;
        tick();
        mem_clear = 1'b0;
    endtask

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int d0;
    logic [7:0] odd_bytes [0:4];

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_state",         32'(state_dbg),      32'(ST_IDLE));
        check("rst_in_ready",      32'(in_ready),       32'd0);
        check("rst_mem_rw",        32'(mem_read_write), 32'd0);
        check("rst_mem_address",   mem_address,         PC);
        check("rst_mem_data_in",   mem_data_in,         32'd0);
        check("rst_busy",          32'(busy),           32'd0);
        check("rst_done",          32'(done),           32'd0);
        check("rst_error",         32'(error),          32'd0);
        check("rst_words_written", words_written,       32'd0);
        reset = 1'b0;
        clear_mem();

        // 8 bytes back-to-back
        exp_q.push_back({PC,          32'h0403_0201});
        exp_q.push_back({PC + 32'd4,  32'h0807_0605});
        d0 = done_cnt;
        start_load(32'd8);
        check("t1_start_in_ready", 32'(in_ready), 32'd1);
        check("t1_busy",           32'(busy),     32'd1);
        send_seq(8'h01, 8, 1'b0);
        wait_done("t1_done_seen");
        check("t1_done_count",     32'(done_cnt - d0), 32'd1);
        check("t1_words_written",  words_written,      32'd2);
        check("t1_error",          32'(error),         32'd0);
        tick();
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check("t1_idle_busy",      32'(busy), 32'd0);
        check("t1_queue_empty",    32'(exp_q.size()), 32'd0);
        check("t1_mem0",           mem_arr[0], 32'h0403_0201);
        check("t1_mem1",           mem_arr[1], 32'h0807_0605);

        // 5 bytes: partial last word
        odd_bytes[0] = 8'hAA; odd_bytes[1] = 8'hBB; odd_bytes[2] = 8'hCC;
        odd_bytes[3] = 8'hDD; odd_bytes[4] = 8'hEE;
        exp_q.push_back({PC,          32'hDDCC_BBAA});
        exp_q.push_back({PC + 32'd4,  32'h0000_00EE});
        start_load(32'd5);
        for (int i = 0; i < 5; i++) send_byte(odd_bytes[i], 1'b0);
        in_valid = 1'b0;
        wait_done("t2_done_seen");
        check("t2_words_written", words_written, 32'd2);
        tick();
        check("t2_queue_empty",   32'(exp_q.size()), 32'd0);
        check("t2_mem1",          mem_arr[1], 32'h0000_00EE);

        // in_valid toggling between bytes
        clear_mem();
        exp_q.push_back({PC,          32'h0403_0201});
        exp_q.push_back({PC + 32'd4,  32'h0807_0605});
        start_load(32'd8);
        send_seq(8'h01, 8, 1'b1);
        wait_done("t3_done_seen");
        check("t3_words_written", words_written, 32'd2);
        tick();
        check("t3_queue_empty",   32'(exp_q.size()), 32'd0);
        check("t3_mem0",          mem_arr[0], 32'h0403_0201);
        check("t3_mem1",          mem_arr[1], 32'h0807_0605);

        // Oversize request: rejected, no writes
        d0 = done_cnt;
        start_load(32'(DEPTH + 1));
        check("t4_done",          32'(done),     32'd1);
        check("t4_error",         32'(error),    32'd1);
        check("t4_in_ready",      32'(in_ready), 32'd0);
        check("t4_words_kept",    words_written, 32'd2);
        tick();
        check("t4_done_cleared",  32'(done),     32'd0);
        check("t4_error_sticky",  32'(error),    32'd1);
        check("t4_done_count",    32'(done_cnt - d0), 32'd1);

        // Zero-length request: done next cycle, no writes
        start_load(32'd0);
        check("t5_done",          32'(done),  32'd1);
        check("t5_error_sticky",  32'(error), 32'd1);
        tick();
        check("t5_idle",          32'(busy),  32'd0);

        // Reset during the WRITE cycle of word 1
        clear_mem();
        exp_q.push_back({PC, 32'h0403_0201});
        start_load(32'd8);
        check("t6_error_cleared", 32'(error), 32'd0);
        send_seq(8'h01, 7, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h08;
        for (int t = 0; t < 40 && !in_ready; t++) tick();
        check("t6_last_byte_ready", 32'(in_ready), 32'd1);
        d0 = done_cnt;
        @(posedge clock);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("t6_write_masked",   32'(mem_read_write), 32'd0);
        tick();
        check("t6_state",          32'(state_dbg),      32'(ST_IDLE));
        check("t6_in_ready",       32'(in_ready),       32'd0);
        check("t6_mem_address",    mem_address,         PC);
        check("t6_mem_data_in",    mem_data_in,         32'd0);
        check("t6_busy",           32'(busy),           32'd0);
        check("t6_words_written",  words_written,       32'd0);
        check("t6_mem0",           mem_arr[0],          32'h0403_0201);
        check("t6_mem1_unwritten", mem_arr[1],          32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("t6_no_done",        32'(done_cnt - d0),  32'd0);
        check("t6_queue_empty",    32'(exp_q.size()),   32'd0);

`ifdef IMEM_LOADER_VERIFY_EN
        // Read-back mismatch on word 0 aborts the load
        clear_mem();
        corrupt = 1'b1;
        exp_q.push_back({PC, 32'h0403_0201});
        start_load(32'd8);
        send_seq(8'h01, 4, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h05;
        wait_done("t7_done_seen");
        check("t7_error",         32'(error),    32'd1);
        check("t7_words_written", words_written, 32'd1);
        check("t7_in_ready",      32'(in_ready), 32'd0);
        repeat (3) tick();
        check("t7_idle",          32'(busy),     32'd0);
        in_valid = 1'b0;
        corrupt  = 1'b0;
        check("t7_queue_empty",   32'(exp_q.size()), 32'd0);
        check("t7_mem1",          mem_arr[1], 32'd0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
